// File: rtl/forward_ctrl.sv
// Hazard and forwarding control for a 5-stage in-order pipeline.
// Shadow copies of EX/MEM/WB drive the operand bypass selects and the load-use stall.
module forward_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_rs1_use_i,
    input  logic        id_rs2_use_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_regwrite_i,
    input  logic        id_memread_i,
    input  logic        flush_i,
    input  logic        freeze_i,
    output logic [1:0]  fwd_a_sel_o,
    output logic [1:0]  fwd_b_sel_o,
    output logic        stall_o,
    output logic        bubble_o,
    output logic [15:0] stall_cnt_o
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_use;
        logic       rs2_use;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } ex_stage_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
    } wr_stage_t;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    ex_stage_t   ex_q, ex_d;
    wr_stage_t   mem_q, mem_d;
    wr_stage_t   wb_q, wb_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        hz;

    // A producer only bypasses if it really writes a non-x0 register matching the source.
    function automatic logic writes_reg(input wr_stage_t st, input logic [4:0] rs);
        return st.valid && st.regwrite && (st.rd != 5'd0) && (st.rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input ex_stage_t ex, input wr_stage_t mem,
                                           input wr_stage_t wb, input logic [4:0] rs,
                                           input logic rs_use);
        logic [1:0] sel;
        sel = SEL_REG;
        if (ex.valid && rs_use) begin
            if (writes_reg(mem, rs))
                sel = SEL_MEM;
            else if (writes_reg(wb, rs))
                sel = SEL_WB;
        end
        return sel;
    endfunction

    assign hz = id_valid_i && ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.rd != 5'd0) &&
                ((id_rs1_use_i && (id_rs1_i == ex_q.rd)) || (id_rs2_use_i && (id_rs2_i == ex_q.rd)));

    assign fwd_a_sel_o = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs1, ex_q.rs1_use);
    assign fwd_b_sel_o = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs2, ex_q.rs2_use);
    assign stall_cnt_o = stall_cnt_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        stall_o     = 1'b0;
        bubble_o    = 1'b0;

        if (freeze_i) begin
            stall_o = 1'b1;
        end else begin
            wb_d  = mem_q;
            mem_d = '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
            ex_d  = '{valid: id_valid_i, rs1: id_rs1_i, rs2: id_rs2_i,
                      rs1_use: id_rs1_use_i, rs2_use: id_rs2_use_i, rd: id_rd_i,
                      regwrite: id_regwrite_i, memread: id_memread_i};
            // Flush wins over a load-use hazard: the stalled instruction is being killed anyway.
            if (flush_i && !rst_i) begin
                ex_d     = '0;
                bubble_o = 1'b1;
            end else if (hz) begin
                ex_d     = '0;
                stall_o  = 1'b1;
                bubble_o = 1'b1;
                if (stall_cnt_q != 16'hFFFF)
                    stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed, table-driven bench for forward_ctrl: one table row per clock cycle,
// followed by hand-written reset-mid-stall and counter-saturation sequences.
module tb_forward_ctrl;

    typedef struct {
        string       name;
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        fl;
        logic        fz;
        logic        st;
        logic        bb;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic        id_rs1_use = 1'b0;
    logic        id_rs2_use = 1'b0;
    logic [4:0]  id_rd = '0;
    logic        id_regwrite = 1'b0;
    logic        id_memread = 1'b0;
    logic        flush = 1'b0;
    logic        freeze = 1'b0;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall;
    logic        bubble;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];

    forward_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_rs1_use_i  (id_rs1_use),
        .id_rs2_use_i  (id_rs2_use),
        .id_rd_i       (id_rd),
        .id_regwrite_i (id_regwrite),
        .id_memread_i  (id_memread),
        .flush_i       (flush),
        .freeze_i      (freeze),
        .fwd_a_sel_o   (fwd_a_sel),
        .fwd_b_sel_o   (fwd_b_sel),
        .stall_o       (stall),
        .bubble_o      (bubble),
        .stall_cnt_o   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic v, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2,
                                input logic [4:0] rd, input logic rw, input logic mr,
                                input logic fl, input logic fz, input logic st, input logic bb,
                                input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] cnt);
        vec_t r;
        r.name = name; r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        r.rd = rd; r.rw = rw; r.mr = mr; r.fl = fl; r.fz = fz;
        r.st = st; r.bb = bb; r.fa = fa; r.fb = fb; r.cnt = cnt;
        return r;
    endfunction

    function automatic vec_t nop(input string name, input logic [1:0] fa, input logic [1:0] fb,
                                 input logic [15:0] cnt);
        return mk(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb, cnt);
    endfunction

    task automatic drive(input vec_t r);
        id_valid    = r.v;
        id_rs1      = r.rs1;
        id_rs2      = r.rs2;
        id_rs1_use  = r.u1;
        id_rs2_use  = r.u2;
        id_rd       = r.rd;
        id_regwrite = r.rw;
        id_memread  = r.mr;
        flush       = r.fl;
        freeze      = r.fz;
    endtask

    task automatic check_outs(input string name, input logic st, input logic bb,
                              input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] cnt);
        check({name, ".stall"},  {15'd0, stall},  {15'd0, st});
        check({name, ".bubble"}, {15'd0, bubble}, {15'd0, bb});
        check({name, ".fwd_a"},  {14'd0, fwd_a_sel}, {14'd0, fa});
        check({name, ".fwd_b"},  {14'd0, fwd_b_sel}, {14'd0, fb});
        check({name, ".cnt"},    stall_cnt, cnt);
    endtask

    // Load x3 followed by a dependent add; expects the stall cycle then the retry cycle.
    task automatic hazard_pair(input string name, input logic [15:0] cnt_before,
                               input logic [15:0] cnt_after);
        drive(mk("lw", 1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk("use", 1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check({name, ".stall"}, {15'd0, stall}, 16'd1);
        check({name, ".cnt_pre"}, stall_cnt, cnt_before);
        @(negedge clk);
        #1;
        check({name, ".retry_stall"}, {15'd0, stall}, 16'd0);
        check({name, ".cnt_post"}, stall_cnt, cnt_after);
        drive(nop("idle", 0, 0, 0));
        @(negedge clk);
    endtask

    initial begin
        // Each row is one cycle: ID inputs, then expected outputs before the next edge.
        //                 name            v rs1 rs2 u1 u2 rd rw mr fl fz  st bb fa     fb     cnt
        vecs.push_back(mk("add5",          1, 1,  2,  1, 1, 5, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("add6_dep",      1, 5,  1,  1, 1, 6, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(nop("ex_fwd",                                                2'b10, 2'b00, 0));
        vecs.push_back(nop("drain0",                                                2'b00, 2'b00, 0));
        vecs.push_back(mk("addi7a",        1, 1,  0,  1, 0, 7, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("addi7b",        1, 2,  0,  1, 0, 7, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("add8_use7",     1, 7,  7,  1, 1, 8, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(nop("priority",                                              2'b10, 2'b10, 0));
        vecs.push_back(mk("addi9",         1, 3,  0,  1, 0, 9, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(nop("gap",                                                   2'b00, 2'b00, 0));
        vecs.push_back(mk("add10_use9",    1, 9,  1,  1, 1, 10, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(nop("wb_fwd",                                                2'b01, 2'b00, 0));
        vecs.push_back(mk("lw3",           1, 1,  0,  1, 0, 3, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("lu_stall",      1, 3,  3,  1, 1, 4, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0));
        vecs.push_back(mk("lu_retry",      1, 3,  3,  1, 1, 4, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(nop("lu_fwd",                                                2'b01, 2'b01, 1));
        vecs.push_back(mk("lw0",           1, 1,  0,  1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk("use0_lw0",      1, 0,  0,  1, 1, 11, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk("addi0",         1, 1,  0,  1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk("use0_addi0",    1, 0,  0,  1, 1, 12, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(nop("x0_sel",                                                2'b00, 2'b00, 1));
        vecs.push_back(mk("lw3b",          1, 1,  0,  1, 0, 3, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk("flush_hz",      1, 3,  3,  1, 1, 4, 1, 0, 1, 0, 0, 1, 2'b00, 2'b00, 1));
        vecs.push_back(nop("post_flush",                                            2'b00, 2'b00, 1));
        vecs.push_back(mk("lw5",           1, 2,  0,  1, 0, 5, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk("freeze1",       1, 1,  5,  1, 1, 6, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk("freeze2",       1, 1,  5,  1, 1, 6, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk("freeze3",       1, 1,  5,  1, 1, 6, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk("thaw_stall",    1, 1,  5,  1, 1, 6, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00, 1));
        vecs.push_back(mk("thaw_retry",    1, 1,  5,  1, 1, 6, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2));
        vecs.push_back(nop("thaw_fwd",                                              2'b00, 2'b01, 2));
        vecs.push_back(mk("lw3c",          1, 1,  0,  1, 0, 3, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2));
        vecs.push_back(mk("nouse",         1, 3,  3,  0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2));
        vecs.push_back(nop("nouse_sel",                                             2'b00, 2'b00, 2));

        // Reset state, including freeze honoured while in reset.
        @(negedge clk);
        #1;
        check_outs("reset", 0, 0, 2'b00, 2'b00, 16'd0);
        freeze = 1'b1;
        #1;
        check({"reset_freeze", ".stall"},  {15'd0, stall},  16'd1);
        check({"reset_freeze", ".bubble"}, {15'd0, bubble}, 16'd0);
        freeze = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            check_outs(vecs[i].name, vecs[i].st, vecs[i].bb, vecs[i].fa, vecs[i].fb, vecs[i].cnt);
            @(negedge clk);
        end

        // Reset asserted in the middle of a load-use stall.
        drive(mk("lw", 1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk("use", 1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("midrst.stall_before", {15'd0, stall}, 16'd1);
        rst = 1'b1;
        #1;
        check_outs("midrst.in_reset", 0, 0, 2'b00, 2'b00, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst.after_release", {15'd0, stall}, 16'd0);
        @(negedge clk);
        #1;
        check("midrst.no_resume", {15'd0, stall}, 16'd0);
        check("midrst.cnt", stall_cnt, 16'd0);
        drive(nop("idle", 0, 0, 0));
        @(negedge clk);
        @(negedge clk);

        // Preload the counter just below saturation, then take two hazards.
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        #1;
        check("sat.preload", stall_cnt, 16'hFFFE);
        @(negedge clk);
        hazard_pair("sat.first", 16'hFFFE, 16'hFFFF);
        hazard_pair("sat.second", 16'hFFFF, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
